// File: rtl/mqtt_demo_axil_regs.sv
// AXI4-Lite register file for the MQTT demo PL, attached to PS7 M_AXI_GP0.
// The map holds a version word, scratch, control, synchronized status, interrupt
// pending/enable and timestamp registers.
// Optional feature: define MQTT_REGS_TIMESTAMP_EN to build the 64-bit free-running
// timestamp counter. Without it, TS_LO and TS_HI read as 0.
module mqtt_demo_axil_regs #(
    parameter logic [31:0] VERSION   = 32'h0001_0000,
    parameter int unsigned EVT_WIDTH = 8
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    input  logic [4:0]           s_axi_awaddr,
    input  logic                 s_axi_awvalid,
    output logic                 s_axi_awready,
    input  logic [31:0]          s_axi_wdata,
    input  logic [3:0]           s_axi_wstrb,
    input  logic                 s_axi_wvalid,
    output logic                 s_axi_wready,
    output logic [1:0]           s_axi_bresp,
    output logic                 s_axi_bvalid,
    input  logic                 s_axi_bready,
    input  logic [4:0]           s_axi_araddr,
    input  logic                 s_axi_arvalid,
    output logic                 s_axi_arready,
    output logic [31:0]          s_axi_rdata,
    output logic [1:0]           s_axi_rresp,
    output logic                 s_axi_rvalid,
    input  logic                 s_axi_rready,
    output logic [31:0]          ctrl_out,
    input  logic [31:0]          status_in,
    input  logic [EVT_WIDTH-1:0] event_in,
    output logic                 irq
);

    localparam logic [2:0] AddrVersion = 3'd0;
    localparam logic [2:0] AddrScratch = 3'd1;
    localparam logic [2:0] AddrCtrl    = 3'd2;
    localparam logic [2:0] AddrStatus  = 3'd3;
    localparam logic [2:0] AddrIrqPend = 3'd4;
    localparam logic [2:0] AddrIrqEn   = 3'd5;
    localparam logic [2:0] AddrTsLo    = 3'd6;
    localparam logic [2:0] AddrTsHi    = 3'd7;

    // Expand the byte strobes into a bit mask.
    function automatic logic [31:0] strb_mask(input logic [3:0] strb);
        return {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
    endfunction

    // Write path state
    logic                 aw_held_q, aw_held_d;
    logic [2:0]           awaddr_q, awaddr_d;
    logic                 w_held_q, w_held_d;
    logic [31:0]          wdata_q, wdata_d;
    logic [3:0]           wstrb_q, wstrb_d;
    logic                 bvalid_q, bvalid_d;

    // Read path state
    logic                 rvalid_q, rvalid_d;
    logic [31:0]          rdata_q, rdata_d;

    // Register contents
    logic [31:0]          scratch_q, scratch_d;
    logic [31:0]          ctrl_q, ctrl_d;
    logic [31:0]          status_meta_q, status_q;
    logic [EVT_WIDTH-1:0] irq_pend_q, irq_pend_d;
    logic [EVT_WIDTH-1:0] irq_en_q, irq_en_d;
    logic                 irq_q;

    logic                 aw_hs, w_hs, ar_hs, wr_exec;
    logic [2:0]           wr_addr;
    logic [31:0]          wr_data, wr_mask;
    logic [EVT_WIDTH-1:0] pend_clr;
    logic [31:0]          rd_mux;
    logic [31:0]          ts_lo, ts_hi;

    // Only the word address matters; byte offset bits are dropped.
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0]};

    assign s_axi_awready = !aw_held_q && !bvalid_q;
    assign s_axi_wready  = !w_held_q && !bvalid_q;
    assign s_axi_arready = !rvalid_q;
    assign s_axi_bvalid  = bvalid_q;
    assign s_axi_bresp   = 2'b00;
    assign s_axi_rvalid  = rvalid_q;
    assign s_axi_rdata   = rdata_q;
    assign s_axi_rresp   = 2'b00;
    assign ctrl_out      = ctrl_q;
    assign irq           = irq_q;

    assign aw_hs   = s_axi_awvalid && s_axi_awready;
    assign w_hs    = s_axi_wvalid && s_axi_wready;
    assign ar_hs   = s_axi_arvalid && s_axi_arready;
    // Each half comes from its holding register or from a handshake this edge.
    assign wr_exec = (aw_held_q || aw_hs) && (w_held_q || w_hs);
    assign wr_addr = aw_held_q ? awaddr_q : s_axi_awaddr[4:2];
    assign wr_data = w_held_q ? wdata_q : s_axi_wdata;
    assign wr_mask = strb_mask(w_held_q ? wstrb_q : s_axi_wstrb);

`ifdef MQTT_REGS_TIMESTAMP_EN
    logic [63:0] ts_cnt_q;
    logic [31:0] ts_hi_shadow_q;

    // Free-running counter; TS_LO reads latch the upper half for a coherent TS_HI.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            ts_cnt_q       <= '0;
            ts_hi_shadow_q <= '0;
        end else begin
            ts_cnt_q <= ts_cnt_q + 64'd1;
            if (ar_hs && s_axi_araddr[4:2] == AddrTsLo) begin
                ts_hi_shadow_q <= ts_cnt_q[63:32];
            end
        end
    end

    assign ts_lo = ts_cnt_q[31:0];
    assign ts_hi = ts_hi_shadow_q;
`else
    assign ts_lo = '0;
    assign ts_hi = '0;
`endif

    // Handshake bookkeeping for the independent AW/W capture and the B/R channels.
    always_comb begin
        aw_held_d = aw_held_q;
        awaddr_d  = awaddr_q;
        w_held_d  = w_held_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        bvalid_d  = bvalid_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        if (wr_exec) begin
            aw_held_d = 1'b0;
            w_held_d  = 1'b0;
            bvalid_d  = 1'b1;
        end else begin
            if (aw_hs) begin
                aw_held_d = 1'b1;
                awaddr_d  = s_axi_awaddr[4:2];
            end
            if (w_hs) begin
                w_held_d = 1'b1;
                wdata_d  = s_axi_wdata;
                wstrb_d  = s_axi_wstrb;
            end
            if (bvalid_q && s_axi_bready) begin
                bvalid_d = 1'b0;
            end
        end
        if (ar_hs) begin
            rvalid_d = 1'b1;
            rdata_d  = rd_mux;
        end else if (rvalid_q && s_axi_rready) begin
            rvalid_d = 1'b0;
        end
    end

    // Register write decode. An event set takes priority over a same-edge W1C clear.
    always_comb begin
        scratch_d = scratch_q;
        ctrl_d    = ctrl_q;
        irq_en_d  = irq_en_q;
        pend_clr  = '0;
        if (wr_exec) begin
            case (wr_addr)
                AddrScratch: scratch_d = (scratch_q & ~wr_mask) | (wr_data & wr_mask);
                AddrCtrl:    ctrl_d    = (ctrl_q & ~wr_mask) | (wr_data & wr_mask);
                AddrIrqPend: pend_clr  = EVT_WIDTH'(wr_data & wr_mask);
                AddrIrqEn:   irq_en_d  = EVT_WIDTH'((32'(irq_en_q) & ~wr_mask)
                                                    | (wr_data & wr_mask));
                default:     ;
            endcase
        end
        irq_pend_d = (irq_pend_q & ~pend_clr) | event_in;
    end

    // Read data selection from current register state.
    always_comb begin
        rd_mux = '0;
        case (s_axi_araddr[4:2])
            AddrVersion: rd_mux = VERSION;
            AddrScratch: rd_mux = scratch_q;
            AddrCtrl:    rd_mux = ctrl_q;
            AddrStatus:  rd_mux = status_q;
            AddrIrqPend: rd_mux = 32'(irq_pend_q);
            AddrIrqEn:   rd_mux = 32'(irq_en_q);
            AddrTsLo:    rd_mux = ts_lo;
            AddrTsHi:    rd_mux = ts_hi;
            default:     rd_mux = '0;
        endcase
    end

    // State registers, status synchronizer and the registered interrupt output.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            aw_held_q     <= 1'b0;
            awaddr_q      <= '0;
            w_held_q      <= 1'b0;
            wdata_q       <= '0;
            wstrb_q       <= '0;
            bvalid_q      <= 1'b0;
            rvalid_q      <= 1'b0;
            rdata_q       <= '0;
            scratch_q     <= '0;
            ctrl_q        <= '0;
            status_meta_q <= '0;
            status_q      <= '0;
            irq_pend_q    <= '0;
            irq_en_q      <= '0;
            irq_q         <= 1'b0;
        end else begin
            aw_held_q     <= aw_held_d;
            awaddr_q      <= awaddr_d;
            w_held_q      <= w_held_d;
            wdata_q       <= wdata_d;
            wstrb_q       <= wstrb_d;
            bvalid_q      <= bvalid_d;
            rvalid_q      <= rvalid_d;
            rdata_q       <= rdata_d;
            scratch_q     <= scratch_d;
            ctrl_q        <= ctrl_d;
            status_meta_q <= status_in;
            status_q      <= status_meta_q;
            irq_pend_q    <= irq_pend_d;
            irq_en_q      <= irq_en_d;
            irq_q         <= |(irq_pend_q & irq_en_q);
        end
    end

endmodule

// File: tb/tb_mqtt_demo_axil_regs.sv
// Directed self-checking bench for mqtt_demo_axil_regs.
module tb_mqtt_demo_axil_regs;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic [4:0]  s_axi_awaddr = '0;
    logic        s_axi_awvalid = 1'b0;
    logic        s_axi_awready;
    logic [31:0] s_axi_wdata = '0;
    logic [3:0]  s_axi_wstrb = '0;
    logic        s_axi_wvalid = 1'b0;
    logic        s_axi_wready;
    logic [1:0]  s_axi_bresp;
    logic        s_axi_bvalid;
    logic        s_axi_bready = 1'b0;
    logic [4:0]  s_axi_araddr = '0;
    logic        s_axi_arvalid = 1'b0;
    logic        s_axi_arready;
    logic [31:0] s_axi_rdata;
    logic [1:0]  s_axi_rresp;
    logic        s_axi_rvalid;
    logic        s_axi_rready = 1'b0;
    logic [31:0] ctrl_out;
    logic [31:0] status_in = '0;
    logic [7:0]  event_in = '0;
    logic        irq;

    int errors = 0;
    int checks = 0;
    int b_rises = 0;
    logic b_prev = 1'b0;
    logic [31:0] rd;
    logic [31:0] lo1, lo2, hi;

    mqtt_demo_axil_regs #(
        .VERSION   (32'h0001_0000),
        .EVT_WIDTH (8)
    ) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .s_axi_awaddr  (s_axi_awaddr),
        .s_axi_awvalid (s_axi_awvalid),
        .s_axi_awready (s_axi_awready),
        .s_axi_wdata   (s_axi_wdata),
        .s_axi_wstrb   (s_axi_wstrb),
        .s_axi_wvalid  (s_axi_wvalid),
        .s_axi_wready  (s_axi_wready),
        .s_axi_bresp   (s_axi_bresp),
        .s_axi_bvalid  (s_axi_bvalid),
        .s_axi_bready  (s_axi_bready),
        .s_axi_araddr  (s_axi_araddr),
        .s_axi_arvalid (s_axi_arvalid),
        .s_axi_arready (s_axi_arready),
        .s_axi_rdata   (s_axi_rdata),
        .s_axi_rresp   (s_axi_rresp),
        .s_axi_rvalid  (s_axi_rvalid),
        .s_axi_rready  (s_axi_rready),
        .ctrl_out      (ctrl_out),
        .status_in     (status_in),
        .event_in      (event_in),
        .irq           (irq)
    );

    always #5 aclk = ~aclk;

    // Count rising edges of bvalid to confirm one response per transaction.
    always @(negedge aclk) begin
        if (s_axi_bvalid && !b_prev) b_rises++;
        b_prev = s_axi_bvalid;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    // AW/W presented at independent cycle offsets; B accepted after b_dly cycles.
    task automatic axi_write(input logic [4:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input int aw_dly, input int w_dly,
                             input int b_dly);
        bit aw_done = 0;
        bit w_done = 0;
        bit aw_fire, w_fire;
        bit hold_ok = 1;
        s_axi_awaddr = addr;
        s_axi_wdata  = data;
        s_axi_wstrb  = strb;
        for (int cyc = 0; cyc < 40 && !(aw_done && w_done); cyc++) begin
            if (cyc == aw_dly) s_axi_awvalid = 1'b1;
            if (cyc == w_dly) s_axi_wvalid = 1'b1;
            aw_fire = s_axi_awvalid && s_axi_awready;
            w_fire  = s_axi_wvalid && s_axi_wready;
            tick();
            if (aw_fire) begin aw_done = 1; s_axi_awvalid = 1'b0; end
            if (w_fire) begin w_done = 1; s_axi_wvalid = 1'b0; end
        end
        chk("wr_handshake", 32'(aw_done && w_done), 32'd1);
        chk("bvalid_up", 32'(s_axi_bvalid), 32'd1);
        chk("bresp", 32'(s_axi_bresp), 32'd0);
        for (int i = 0; i < b_dly; i++) begin
            tick();
            if (s_axi_bvalid !== 1'b1 || s_axi_awready !== 1'b0 || s_axi_wready !== 1'b0)
                hold_ok = 0;
        end
        if (b_dly > 0) chk("b_backpressure", 32'(hold_ok), 32'd1);
        s_axi_bready = 1'b1;
        tick();
        s_axi_bready = 1'b0;
        chk("bvalid_drop", 32'(s_axi_bvalid), 32'd0);
    endtask

    // AR handshake, then R accepted after r_dly cycles with rdata checked for stability.
    task automatic axi_read(input logic [4:0] addr, input int r_dly, output logic [31:0] data);
        bit done = 0;
        bit fire;
        bit stable = 1;
        s_axi_araddr  = addr;
        s_axi_arvalid = 1'b1;
        for (int cyc = 0; cyc < 20 && !done; cyc++) begin
            fire = s_axi_arvalid && s_axi_arready;
            tick();
            if (fire) begin done = 1; s_axi_arvalid = 1'b0; end
        end
        chk("rd_handshake", 32'(done), 32'd1);
        chk("rvalid_up", 32'(s_axi_rvalid), 32'd1);
        chk("rresp", 32'(s_axi_rresp), 32'd0);
        data = s_axi_rdata;
        for (int i = 0; i < r_dly; i++) begin
            tick();
            if (s_axi_rdata !== data || s_axi_rvalid !== 1'b1 || s_axi_arready !== 1'b0)
                stable = 0;
        end
        if (r_dly > 0) chk("r_backpressure", 32'(stable), 32'd1);
        s_axi_rready = 1'b1;
        tick();
        s_axi_rready = 1'b0;
    endtask

    initial begin
        // Reset state, sampled while reset is held
        #2;
        chk("rst_awready", 32'(s_axi_awready), 32'd1);
        chk("rst_wready", 32'(s_axi_wready), 32'd1);
        chk("rst_arready", 32'(s_axi_arready), 32'd1);
        chk("rst_bvalid", 32'(s_axi_bvalid), 32'd0);
        chk("rst_rvalid", 32'(s_axi_rvalid), 32'd0);
        chk("rst_irq", 32'(irq), 32'd0);
        chk("rst_ctrl", ctrl_out, 32'd0);
        tick();
        tick();
        aresetn = 1'b1;
        tick();

        // Post-reset reads
        axi_read(5'h00, 0, rd);
        chk("version", rd, 32'h0001_0000);
        axi_read(5'h04, 0, rd);
        chk("scratch_rst", rd, 32'h0000_0000);

        // AW before W, then W before AW, with byte strobes
        b_rises = 0;
        axi_write(5'h04, 32'hDEAD_BEEF, 4'b0101, 0, 2, 0);
        axi_read(5'h04, 0, rd);
        chk("scratch_aw_first", rd, 32'h00AD_00EF);
        axi_write(5'h04, 32'h1234_5678, 4'b1010, 2, 0, 0);
        axi_read(5'h04, 0, rd);
        chk("scratch_w_first", rd, 32'h12AD_56EF);
        chk("one_b_per_write", 32'(b_rises), 32'd2);

        // B and R backpressure on CTRL
        axi_write(5'h08, 32'h0000_00A5, 4'b1111, 0, 0, 5);
        chk("ctrl_out", ctrl_out, 32'h0000_00A5);
        axi_read(5'h08, 5, rd);
        chk("ctrl_read", rd, 32'h0000_00A5);

        // Writes to read-only VERSION are ignored
        axi_write(5'h00, 32'hFFFF_FFFF, 4'b1111, 0, 0, 0);
        axi_read(5'h00, 0, rd);
        chk("version_ro", rd, 32'h0001_0000);

        // Synchronized status
        status_in = 32'hCAFE_F00D;
        tick();
        tick();
        tick();
        axi_read(5'h0C, 0, rd);
        chk("status", rd, 32'hCAFE_F00D);

        // IRQ_EN keeps only implemented bits
        axi_write(5'h14, 32'hFFFF_FFFF, 4'b1111, 0, 0, 0);
        axi_read(5'h14, 0, rd);
        chk("irq_en_width", rd, 32'h0000_00FF);
        axi_write(5'h14, 32'h0000_0004, 4'b1111, 0, 0, 0);

        // Event pulse -> pending next edge -> irq one edge later
        event_in = 8'h04;
        tick();
        event_in = 8'h00;
        chk("irq_not_yet", 32'(irq), 32'd0);
        tick();
        chk("irq_set", 32'(irq), 32'd1);
        axi_read(5'h10, 0, rd);
        chk("pend_set", rd, 32'h0000_0004);

        // W1C clear racing a new event on the same edge: the set wins
        s_axi_awaddr  = 5'h10;
        s_axi_wdata   = 32'h0000_0004;
        s_axi_wstrb   = 4'b1111;
        s_axi_awvalid = 1'b1;
        s_axi_wvalid  = 1'b1;
        event_in      = 8'h04;
        tick();
        s_axi_awvalid = 1'b0;
        s_axi_wvalid  = 1'b0;
        event_in      = 8'h00;
        chk("race_bvalid", 32'(s_axi_bvalid), 32'd1);
        s_axi_bready = 1'b1;
        tick();
        s_axi_bready = 1'b0;
        chk("race_irq", 32'(irq), 32'd1);
        axi_read(5'h10, 0, rd);
        chk("race_pend", rd, 32'h0000_0004);

        // A plain clear drops the bit, irq follows one edge later
        axi_write(5'h10, 32'h0000_0004, 4'b1111, 0, 0, 0);
        chk("irq_cleared", 32'(irq), 32'd0);
        axi_read(5'h10, 0, rd);
        chk("pend_cleared", rd, 32'h0000_0000);

        // Same-edge read and write of SCRATCH: the read sees the old value
        s_axi_araddr  = 5'h04;
        s_axi_arvalid = 1'b1;
        s_axi_awaddr  = 5'h04;
        s_axi_wdata   = 32'h1111_1111;
        s_axi_wstrb   = 4'b1111;
        s_axi_awvalid = 1'b1;
        s_axi_wvalid  = 1'b1;
        tick();
        s_axi_arvalid = 1'b0;
        s_axi_awvalid = 1'b0;
        s_axi_wvalid  = 1'b0;
        chk("rw_rvalid", 32'(s_axi_rvalid), 32'd1);
        chk("rw_old_value", s_axi_rdata, 32'h12AD_56EF);
        s_axi_rready = 1'b1;
        s_axi_bready = 1'b1;
        tick();
        s_axi_rready = 1'b0;
        s_axi_bready = 1'b0;
        axi_read(5'h04, 0, rd);
        chk("rw_new_value", rd, 32'h1111_1111);

        // Timestamp
`ifdef MQTT_REGS_TIMESTAMP_EN
        axi_read(5'h18, 0, lo1);
        repeat (100) tick();
        axi_read(5'h1C, 0, hi);
        chk("ts_hi_snapshot", hi, 32'h0000_0000);
        axi_read(5'h18, 0, lo2);
        chk("ts_lo_advance", 32'((lo2 - lo1) >= 32'd100), 32'd1);
`else
        axi_read(5'h18, 0, lo1);
        chk("ts_lo_zero", lo1, 32'h0000_0000);
        repeat (100) tick();
        axi_read(5'h1C, 0, hi);
        chk("ts_hi_zero", hi, 32'h0000_0000);
`endif

        // Reset between AW and W
        s_axi_awaddr  = 5'h04;
        s_axi_awvalid = 1'b1;
        tick();
        s_axi_awvalid = 1'b0;
        chk("aw_held_ready", 32'(s_axi_awready), 32'd0);
        aresetn = 1'b0;
        #1;
        chk("midrst_bvalid", 32'(s_axi_bvalid), 32'd0);
        chk("midrst_awready", 32'(s_axi_awready), 32'd1);
        chk("midrst_ctrl", ctrl_out, 32'd0);
        tick();
        aresetn = 1'b1;
        tick();
        chk("postrst_bvalid", 32'(s_axi_bvalid), 32'd0);
        axi_read(5'h04, 0, rd);
        chk("postrst_scratch", rd, 32'h0000_0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mqtt_demo_axil_regs.md
# mqtt_demo_axil_regs

AXI4-Lite slave register file answering the Zynq PS7 general-purpose master port (M_AXI_GP0) in the MQTT demo. It terminates PS-initiated register reads and writes. It provides:
- a version word and a scratch register,
- control outputs to the PL,
- sampled status inputs,
- an event-driven interrupt with pending/enable registers,
- an optional 64-bit timestamp.

It sits between the PS7 block-design wrapper's AXI master and the demo's PL logic.

## Interface
- VERSION, 32'h0001_0000, constant returned at offset 0x00
- EVT_WIDTH, 8, number of event/interrupt sources (1..32)
- aclk  in  1  sole clock; all logic on rising edge
- aresetn  in  1  reset, asynchronous assert, active-low
- s_axi_awaddr  in  5  write address; bits [4:2] decoded, [1:0] ignored
- s_axi_awvalid / s_axi_awready  in / out  1  write-address handshake
- s_axi_wdata  in  32  write data
- s_axi_wstrb  in  4  byte enables
- s_axi_wvalid / s_axi_wready  in / out  1  write-data handshake
- s_axi_bresp  out  2  always 2'b00 (OKAY)
- s_axi_bvalid / s_axi_bready  out / in  1  write-response handshake
- s_axi_araddr  in  5  read address; bits [4:2] decoded
- s_axi_arvalid / s_axi_arready  in / out  1  read-address handshake
- s_axi_rdata  out  32  read data
- s_axi_rresp  out  2  always 2'b00
- s_axi_rvalid / s_axi_rready  out / in  1  read-data handshake
- ctrl_out  out  32  contents of CTRL
- status_in  in  32  asynchronous status; two-flop synchronized before read
- event_in  in  EVT_WIDTH  single-cycle event pulses, aclk domain
- irq  out  1  registered, level-high interrupt to PS IRQ_F2P

## Operation
Register map:
- 0x00 VERSION: read-only.
- 0x04 SCRATCH: read/write.
- 0x08 CTRL: read/write; drives ctrl_out.
- 0x0C STATUS: read-only; synchronized status_in.
- 0x10 IRQ_PEND: write-1-to-clear. Bit i is set by event_in[i].
- 0x14 IRQ_EN: read/write. Bits at or above EVT_WIDTH read 0.
- 0x18 TS_LO: read-only.
- 0x1C TS_HI: read-only.

Write and byte-strobe rules:
- Writes to read-only offsets are accepted and ignored, with an OKAY response.
- wstrb applies per byte to the read/write registers and to IRQ_PEND clears.

Write path:
- AW and W are captured independently into holding registers.
- awready = !aw_held && !bvalid.
- wready = !w_held && !bvalid.
- The write executes on the edge where both the address and the data are available. Each may come from its holding register or from a handshake on that same edge. bvalid rises on the same edge.
- bvalid holds until bready. The holding registers clear when the write executes.

Read path:
- arready = !rvalid.
- On an AR handshake, rdata and rvalid are registered on that edge.
- rdata holds stable until rready.

Read side effects:
- Reading TS_LO snapshots the counter's upper half into a TS_HI shadow. TS_HI reads return the shadow.
- Reads have no other side effects.

Interrupt:
- irq is registered as irq <= |(IRQ_PEND & IRQ_EN).

## Timing
Reset values:
- All registers, bvalid, rvalid, rdata, irq and ctrl_out are 0.
- awready, wready and arready are 1 during and after reset. They are combinational from state.

Latency and throughput:
- Write: AW and W handshaken on edge N → register updated and bvalid = 1 after edge N. The write is visible to a read whose AR handshake occurs at edge N+1 or later.
- Read: AR on edge N → rvalid after edge N. Maximum throughput is one read per 2 cycles, because arready is low while rvalid is high.
- Same-edge read and write: the read returns the old value.

Interrupt timing:
- event_in pulse on edge N → IRQ_PEND bit set after edge N → irq after edge N+1.
- A set and a W1C clear of the same bit on the same edge: the set wins.

Other boundary conditions:
- STATUS read reflects status_in as of 2 or more edges earlier.
- aresetn asserted mid-transaction: all state clears immediately, and in-flight responses are dropped.

## Configuration
- MQTT_REGS_TIMESTAMP_EN defined:
  - A 64-bit free-running counter increments every aclk. It wraps from 2^64-1 to 0 and is reset to 0.
  - TS_LO and TS_HI behave as above.
- Not defined:
  - No counter is built.
  - TS_LO and TS_HI read 0.
  - All other behaviour is identical.

## Test plan
- Post-reset reads: read 0x00 → VERSION (32'h0001_0000); read 0x04 → 0; bresp and rresp = 0.
- Write ordering and strobes: AW two cycles before W, then W two cycles before AW, to 0x04 with wdata 32'hDEAD_BEEF and wstrb 4'b0101. Required: one bvalid per transaction, and readback 32'h00AD_00EF.
- Backpressure: bready held low 5 cycles → bvalid stays high, and awready/wready stay low. Then rready held low → rdata stays stable.
- Interrupt: IRQ_EN = 8'h04, pulse event_in[2] → irq high 2 edges later. Write 32'h4 to 0x10 with a concurrent event_in[2] pulse → the bit stays set and irq stays high. A later clear → irq low.
- Timestamp (macro defined): read TS_LO, wait 100 cycles, read TS_HI → the value matches the snapshot taken at the TS_LO read. A second TS_LO read is at least 100 greater. With the macro undefined, both read 0.
- Reset mid-write: aresetn low after the AW handshake but before W → no register change, bvalid = 0, and awready = 1.
